// File: rtl/result_bus_arbiter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : result_bus_arbiter_pkg
// Description : Shared types and widths for the CDB result-bus arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package result_bus_arbiter_pkg;

  localparam int c_REG_ADDR_W = 5;
  localparam int c_DATA_W     = 32;

  // CR0 field (LT/GT/EQ/SO) plus the XER sticky/overflow/carry bits
  typedef struct packed {
    logic [3:0] cr0;
    logic       xer_so;
    logic       xer_ov;
    logic       xer_ca;
  } cond_exception_t;

endpackage
`default_nettype wire

// File: rtl/result_bus_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : result_bus_arbiter_if
// Description : Execution-unit result streams in, common data bus out.
// Revision    : 1.0 - initial release
// ============================================================================
interface result_bus_arbiter_if #(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
);
  import result_bus_arbiter_pkg::*;

  localparam int c_UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;

  logic                                      flush;
  logic                                      cdb_stall;
  logic [UNITS-1:0]                          unit_valid;
  logic [UNITS-1:0]                          unit_ready;
  logic [UNITS-1:0][RS_ID_WIDTH-1:0]         unit_rs_id;
  logic [UNITS-1:0][c_REG_ADDR_W-1:0]        unit_reg_addr;
  logic [UNITS-1:0][c_DATA_W-1:0]            unit_result;
  cond_exception_t [UNITS-1:0]               unit_cr0_xer;

  logic                                      cdb_valid;
  logic [RS_ID_WIDTH-1:0]                    cdb_rs_id;
  logic [c_REG_ADDR_W-1:0]                   cdb_reg_addr;
  logic [c_DATA_W-1:0]                       cdb_value;
  cond_exception_t                           cdb_cr0_xer;
  logic [c_UNIT_W-1:0]                       cdb_unit;

  modport master (
    output flush, cdb_stall, unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer,
    input  unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer, cdb_unit
  );

  modport slave (
    input  flush, cdb_stall, unit_valid, unit_rs_id, unit_reg_addr, unit_result, unit_cr0_xer,
    output unit_ready, cdb_valid, cdb_rs_id, cdb_reg_addr, cdb_value, cdb_cr0_xer, cdb_unit
  );

endinterface
`default_nettype wire

// File: rtl/result_bus_arbiter_rr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : rr_arbiter
// Description : Combinational round-robin search starting at ptr, wrapping mod N.
// Revision    : 1.0 - initial release
// ============================================================================
module rr_arbiter #(
  parameter  int N = 4,
  localparam int W = (N > 1) ? $clog2(N) : 1
) (
  input  wire logic [N-1:0] req,
  input  wire logic [W-1:0] ptr,
  output logic      [N-1:0] grant,
  output logic      [W-1:0] idx,
  output logic              any
);

  logic [W:0]   w_sum;
  logic [W-1:0] w_cand;

  // ptr < N and k < N, so one conditional subtract gives the modulo
  always_comb begin
    grant  = '0;
    idx    = '0;
    any    = 1'b0;
    w_sum  = '0;
    w_cand = '0;
    for (int k = 0; k < N; k++) begin
      w_sum = {1'b0, ptr} + (W+1)'(k);
      if (w_sum >= (W+1)'(N)) begin
        w_sum = w_sum - (W+1)'(N);
      end
      w_cand = w_sum[W-1:0];
      if (!any && req[w_cand]) begin
        any           = 1'b1;
        grant[w_cand] = 1'b1;
        idx           = w_cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : result_bus_arbiter
// Description : Round-robin serialiser of execution-unit results onto a registered CDB.
// Revision    : 1.0 - initial release
// ============================================================================
module result_bus_arbiter
  import result_bus_arbiter_pkg::*;
#(
  parameter int UNITS       = 4,
  parameter int RS_ID_WIDTH = 5
) (
  input  wire logic            clk,
  input  wire logic            rst_n,
  result_bus_arbiter_if.slave  bus
);

  localparam int              c_UNIT_W = (UNITS > 1) ? $clog2(UNITS) : 1;
  localparam logic [c_UNIT_W-1:0] c_LAST = c_UNIT_W'(UNITS - 1);

  typedef struct packed {
    logic [RS_ID_WIDTH-1:0]  rs_id;
    logic [c_REG_ADDR_W-1:0] reg_addr;
    logic [c_DATA_W-1:0]     value;
    cond_exception_t         cr0_xer;
  } cdb_entry_t;

  cdb_entry_t          r_entry;
  logic                r_cdb_valid;
  logic [c_UNIT_W-1:0] r_cdb_unit;
  logic [c_UNIT_W-1:0] r_rr_ptr;

  logic [UNITS-1:0]    w_grant;
  logic [c_UNIT_W-1:0] w_winner;
  logic                w_any;
  logic                w_can_load;
  logic                w_handshake;

  rr_arbiter #(.N(UNITS)) u_rr_arbiter (
    .req   (bus.unit_valid),
    .ptr   (r_rr_ptr),
    .grant (w_grant),
    .idx   (w_winner),
    .any   (w_any)
  );

  // rst_n gating keeps every ready low while reset is held
  assign w_can_load     = rst_n && !bus.flush && (!r_cdb_valid || !bus.cdb_stall);
  assign w_handshake    = w_can_load && w_any;
  assign bus.unit_ready = w_can_load ? w_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_entry     <= '0;
      r_cdb_valid <= 1'b0;
      r_cdb_unit  <= '0;
      r_rr_ptr    <= '0;
    end else if (bus.flush) begin
      r_cdb_valid <= 1'b0;
    end else if (w_can_load) begin
      r_cdb_valid <= w_handshake;
      if (w_handshake) begin
        r_entry.rs_id    <= bus.unit_rs_id[w_winner];
        r_entry.reg_addr <= bus.unit_reg_addr[w_winner];
        r_entry.value    <= bus.unit_result[w_winner];
        r_entry.cr0_xer  <= bus.unit_cr0_xer[w_winner];
        r_cdb_unit       <= w_winner;
        r_rr_ptr         <= (w_winner == c_LAST) ? '0 : w_winner + 1'b1;
      end
    end
  end

  assign bus.cdb_valid    = r_cdb_valid;
  assign bus.cdb_rs_id    = r_entry.rs_id;
  assign bus.cdb_reg_addr = r_entry.reg_addr;
  assign bus.cdb_value    = r_entry.value;
  assign bus.cdb_cr0_xer  = r_entry.cr0_xer;
  assign bus.cdb_unit     = r_cdb_unit;

endmodule
`default_nettype wire

// File: tb/tb_result_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_result_bus_arbiter
// Description : Directed self-checking bench for result_bus_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_result_bus_arbiter;
  import result_bus_arbiter_pkg::*;

  localparam int c_UNITS = 4;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  result_bus_arbiter_if #(.UNITS(c_UNITS), .RS_ID_WIDTH(5)) bus ();

  result_bus_arbiter #(.UNITS(c_UNITS), .RS_ID_WIDTH(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] exp_value(input int u);
    return 32'h1000_0000 * (u + 1) + 32'(u * 3 + 1);
  endfunction
  function automatic logic [4:0] exp_rs_id(input int u);
    return 5'(u + 3);
  endfunction
  function automatic logic [4:0] exp_reg(input int u);
    return 5'(u * 7 + 1);
  endfunction
  function automatic logic [6:0] exp_flags(input int u);
    return 7'(7'h55 ^ u);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Checks the full CDB broadcast against the payload of unit u
  task automatic check_cdb(input string name, input int u);
    n_checks++;
    if (bus.cdb_valid !== 1'b1 || bus.cdb_unit !== 2'(u) || bus.cdb_value !== exp_value(u) ||
        bus.cdb_rs_id !== exp_rs_id(u) || bus.cdb_reg_addr !== exp_reg(u) ||
        bus.cdb_cr0_xer !== exp_flags(u)) begin
      n_fail++;
      $display("FAIL %s: valid=%b unit=%0d value=%h rs=%h reg=%h fl=%h, expected unit %0d value %h",
               name, bus.cdb_valid, bus.cdb_unit, bus.cdb_value, bus.cdb_rs_id,
               bus.cdb_reg_addr, bus.cdb_cr0_xer, u, exp_value(u));
    end
  endtask

  task automatic check_ready(input string name, input logic [3:0] exp);
    n_checks++;
    if (bus.unit_ready !== exp) begin
      n_fail++;
      $display("FAIL %s: unit_ready=%b expected %b", name, bus.unit_ready, exp);
    end
  endtask

  task automatic check_idle(input string name);
    n_checks++;
    if (bus.cdb_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s: cdb_valid=%b expected 0", name, bus.cdb_valid);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.flush = 1'b0;
    bus.cdb_stall = 1'b0;
    bus.unit_valid = 4'b0000;
    for (int u = 0; u < c_UNITS; u++) begin
      bus.unit_rs_id[u]    = exp_rs_id(u);
      bus.unit_reg_addr[u] = exp_reg(u);
      bus.unit_result[u]   = exp_value(u);
      bus.unit_cr0_xer[u]  = exp_flags(u);
    end
    tick();
    tick();
    bus.unit_valid = 4'b1111;
    #1;
    n_checks++;
    if (bus.cdb_valid !== 1'b0 || bus.cdb_value !== 32'h0 || bus.cdb_unit !== 2'd0 ||
        bus.cdb_rs_id !== 5'h0 || bus.cdb_reg_addr !== 5'h0 || bus.cdb_cr0_xer !== 7'h0) begin
      n_fail++;
      $display("FAIL reset_state: valid=%b value=%h unit=%0d, expected all zero",
               bus.cdb_valid, bus.cdb_value, bus.cdb_unit);
    end
    check_ready("reset_ready", 4'b0000);
    bus.unit_valid = 4'b0000;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    bus.unit_valid = 4'b0100;
    #1;
    check_ready("single_ready", 4'b0100);
    tick();
    bus.unit_valid = 4'b0000;
    check_cdb("single_cdb", 2);
    tick();
    check_idle("single_drop");
  endtask

  // rr_ptr is 3 after the single-unit test
  task automatic test_wrap();
    bus.unit_valid = 4'b1010;
    #1;
    check_ready("wrap_ready3", 4'b1000);
    tick();
    bus.unit_valid = 4'b0010;
    check_cdb("wrap_cdb3", 3);
    #1;
    check_ready("wrap_ready1", 4'b0010);
    tick();
    bus.unit_valid = 4'b0000;
    check_cdb("wrap_cdb1", 1);
    tick();
  endtask

  task automatic test_round_robin();
    logic [3:0] oh;
    rst_n = 1'b0;
    #1;
    rst_n = 1'b1;
    bus.unit_valid = 4'b1111;
    #1;
    for (int i = 0; i < 6; i++) begin
      oh = 4'b0001 << (i % 4);
      check_ready($sformatf("rr_ready_%0d", i), oh);
      tick();
      check_cdb($sformatf("rr_cdb_%0d", i), i % 4);
      #1;
    end
    bus.unit_valid = 4'b0000;
    tick();
    check_idle("rr_drain");
  endtask

  // rr_ptr is 2 here; unit 0 still wins as the only requester
  task automatic test_stall();
    bus.unit_valid = 4'b0001;
    #1;
    check_ready("stall_first_ready", 4'b0001);
    tick();
    bus.unit_valid = 4'b0010;
    bus.cdb_stall  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check_ready($sformatf("stall_ready_%0d", i), 4'b0000);
      check_cdb($sformatf("stall_hold_%0d", i), 0);
      tick();
    end
    bus.cdb_stall = 1'b0;
    #1;
    check_ready("stall_release_ready", 4'b0010);
    tick();
    bus.unit_valid = 4'b0000;
    check_cdb("stall_next", 1);
    tick();
    check_idle("stall_no_dup");
  endtask

  task automatic test_flush();
    bus.unit_valid = 4'b0100;
    tick();
    check_cdb("flush_pre", 2);
    bus.unit_valid = 4'b0001;
    bus.flush      = 1'b1;
    #1;
    check_ready("flush_ready", 4'b0000);
    tick();
    check_idle("flush_drop");
    bus.flush = 1'b0;
    #1;
    check_ready("flush_after_ready", 4'b0001);
    tick();
    bus.unit_valid = 4'b0000;
    check_cdb("flush_after_cdb", 0);
    tick();
  endtask

  task automatic test_async_reset();
    bus.unit_valid = 4'b0100;
    tick();
    bus.unit_valid = 4'b1010;
    check_cdb("areset_pre", 2);
    #2;
    rst_n = 1'b0;
    #1;
    check_idle("areset_valid");
    check_ready("areset_ready", 4'b0000);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check_ready("areset_first_grant", 4'b0010);
    tick();
    bus.unit_valid = 4'b0000;
    check_cdb("areset_first_cdb", 1);
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_single();
    test_wrap();
    test_round_robin();
    test_stall();
    test_flush();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
